// File: rtl/integer_unit_pkg.sv
// Shared integer-unit types: BMU writeback packet and ROB tag.
package integer_unit_pkg;

  localparam int BMU_DATA_WIDTH = 32;
  localparam int BMU_TAG_WIDTH  = 6;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [BMU_TAG_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic [BMU_DATA_WIDTH-1:0] result;
    rob_tag_t                  tag;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } bmu_wb_packet_t;

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO with flush, occupancy counter and a head view of
// the oldest entry; pointers wrap naturally, occupancy is tracked separately.
module result_fifo
  import integer_unit_pkg::*;
#(
  parameter type entry_t = bmu_wb_packet_t,
  parameter int  DEPTH   = 4,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] occupancy_o
);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   occ_reg;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & (occ_reg != '0) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + CW'(1);
        2'b01:   occ_reg <= occ_reg - CW'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Storage needs no reset: contents are ignored while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_data_i;
  end

  assign head_o      = mem[rd_ptr_reg];
  assign occupancy_o = occ_reg;

endmodule

// File: rtl/bmu_result_buffer.sv
// Pairs 1-cycle BMU results with issue tag/dest and queues them for writeback.
// Optional same-cycle bypass when empty: define BMU_RESULT_BYPASS_EN.
module bmu_result_buffer
  import integer_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [TAG_WIDTH-1:0]     issue_tag_i,
  input  logic [4:0]               issue_dest_i,
  input  logic [DATA_WIDTH-1:0]    bmu_result_i,
  input  logic                     bmu_valid_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [DATA_WIDTH-1:0]    wb_result_o,
  output logic [TAG_WIDTH-1:0]     wb_tag_o,
  output logic [4:0]               wb_dest_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     protocol_error_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic [TAG_WIDTH-1:0]      tag;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } packet_t;

  logic                 inflight_valid_reg;
  logic [TAG_WIDTH-1:0] inflight_tag_reg;
  logic [4:0]           inflight_dest_reg;
  logic                 protocol_error_reg;

  logic                 issue_accept;
  logic                 push_req;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_occ;
  logic [CW:0]          committed;
  packet_t              incoming;
  packet_t              head;
  packet_t              wb_pkt;

  // Credit counts the in-flight slot, so every BMU result has a home.
  assign committed     = {1'b0, fifo_occ} + (CW+1)'(inflight_valid_reg);
  assign issue_ready_o = ~flush_i & (committed < (CW+1)'(DEPTH));
  assign issue_accept  = issue_valid_i & issue_ready_o;

  assign push_req   = bmu_valid_i & inflight_valid_reg & ~flush_i;
  assign incoming   = '{result: bmu_result_i, tag: inflight_tag_reg, dest: inflight_dest_reg};
  assign fifo_empty = (fifo_occ == '0);

`ifdef BMU_RESULT_BYPASS_EN
  // Empty FIFO: show the incoming result now and skip the write if taken.
  assign wb_valid_o = ~fifo_empty | push_req;
  assign wb_pkt     = fifo_empty ? incoming : head;
  assign fifo_push  = push_req & ~(fifo_empty & wb_ready_i);
  assign fifo_pop   = ~fifo_empty & wb_ready_i;
`else
  assign wb_valid_o = ~fifo_empty;
  assign wb_pkt     = head;
  assign fifo_push  = push_req;
  assign fifo_pop   = wb_valid_o & wb_ready_i;
`endif

  assign wb_result_o      = wb_pkt.result;
  assign wb_tag_o         = wb_pkt.tag;
  assign wb_dest_o        = wb_pkt.dest;
  assign occupancy_o      = fifo_occ;
  assign protocol_error_o = protocol_error_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_valid_reg <= 1'b0;
      inflight_tag_reg   <= '0;
      inflight_dest_reg  <= '0;
      protocol_error_reg <= 1'b0;
    end else begin
      // issue_ready_o is low during flush, so acceptance already excludes it.
      inflight_valid_reg <= issue_accept;
      if (issue_accept) begin
        inflight_tag_reg  <= issue_tag_i;
        inflight_dest_reg <= issue_dest_i;
      end
      if (bmu_valid_i & ~inflight_valid_reg) protocol_error_reg <= 1'b1;
    end
  end

  result_fifo #(
    .entry_t (packet_t),
    .DEPTH   (DEPTH)
  ) u_result_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (incoming),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .occupancy_o (fifo_occ)
  );

endmodule

// File: tb/tb_bmu_result_buffer.sv
// Self-checking bench: table of single ops plus backpressure, drain, streaming,
// flush, orphan-result and async-reset sequences against a scoreboard queue.
module tb_bmu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef BMU_RESULT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          flush_i;
  logic          issue_valid_i;
  logic          issue_ready_o;
  logic [5:0]    issue_tag_i;
  logic [4:0]    issue_dest_i;
  logic [31:0]   bmu_result_i;
  logic          bmu_valid_i;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [31:0]   wb_result_o;
  logic [5:0]    wb_tag_o;
  logic [4:0]    wb_dest_o;
  logic [CW-1:0] occupancy_o;
  logic          protocol_error_o;

  bmu_result_buffer #(.DATA_WIDTH(32), .TAG_WIDTH(6), .DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_tag_i      (issue_tag_i),
    .issue_dest_i     (issue_dest_i),
    .bmu_result_i     (bmu_result_i),
    .bmu_valid_i      (bmu_valid_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_tag_o         (wb_tag_o),
    .wb_dest_o        (wb_dest_o),
    .occupancy_o      (occupancy_o),
    .protocol_error_o (protocol_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  tag;
    logic [4:0]  dest;
  } pkt_t;

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  dest;
    logic [31:0] result;
    pkt_t        exp;
  } vec_t;

  pkt_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          delivered = 0;
  logic [31:0] issue_res = '0;
  logic        orphan_req = 1'b0;
  logic        acc_s = 1'b0;
  logic        orph_s = 1'b0;
  pkt_t        cap;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // BMU model: a result appears exactly one cycle after an accepted issue.
  always @(negedge clk_i) begin
    acc_s  = rst_n_i & issue_valid_i & issue_ready_o & ~flush_i;
    orph_s = rst_n_i & orphan_req;
    if (acc_s) cap = '{result: issue_res, tag: issue_tag_i, dest: issue_dest_i};
  end

  always @(posedge clk_i) begin
    #1;
    bmu_valid_i  = acc_s | orph_s;
    bmu_result_i = acc_s ? cap.result : 32'hBAD0_0000;
    if (acc_s) exp_q.push_back(cap);
  end

  // Writeback monitor: every handshake is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_n_i && !flush_i && wb_valid_o && wb_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL wb_unexpected: got tag %0d with empty scoreboard, required none", wb_tag_o);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        check("wb_result", 64'(wb_result_o), 64'(e.result));
        check("wb_tag", 64'(wb_tag_o), 64'(e.tag));
        check("wb_dest", 64'(wb_dest_o), 64'(e.dest));
        delivered++;
        $display("[TB] wb tag=%0d dest=%0d result=%08h", wb_tag_o, wb_dest_o, wb_result_o);
      end
    end
  end

  // Full buffer must never offer credit (a push while full is unreachable).
  always @(negedge clk_i) begin
    if (rst_n_i && occupancy_o == CW'(DEPTH))
      check("full_no_credit", 64'(issue_ready_o), 64'd0);
  end

  vec_t vecs[4];
  int   nt;
  int   base;

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_tag_i = '0;
    issue_dest_i = '0; bmu_result_i = '0; bmu_valid_i = 1'b0; wb_ready_i = 1'b0;

    vecs[0] = '{6'd5,  5'd3,  32'hDEADBEEF, '{32'hDEADBEEF, 6'd5,  5'd3}};
    vecs[1] = '{6'd0,  5'd0,  32'h00000000, '{32'h00000000, 6'd0,  5'd0}};
    vecs[2] = '{6'd63, 5'd31, 32'hFFFFFFFF, '{32'hFFFFFFFF, 6'd63, 5'd31}};
    vecs[3] = '{6'd42, 5'd17, 32'h12345678, '{32'h12345678, 6'd42, 5'd17}};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_occupancy", 64'(occupancy_o), 64'd0);
    check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst_perr", 64'(protocol_error_o), 64'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    wb_ready_i = 1'b1;

    // Table: single ops with wb_ready=1, latency and payload checked
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_tag_i   = vecs[i].tag;
      issue_dest_i  = vecs[i].dest;
      issue_res     = vecs[i].result;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_i);
        if (c == LAT - 1) check($sformatf("single%0d_early", i), 64'(wb_valid_o), 64'd0);
        if (c == LAT) begin
          check($sformatf("single%0d_valid", i), 64'(wb_valid_o), 64'd1);
          check($sformatf("single%0d_pkt", i), 64'({wb_result_o, wb_tag_o, wb_dest_o}), 64'(vecs[i].exp));
        end
        if (c == LAT + 1) check($sformatf("single%0d_gone", i), 64'(wb_valid_o), 64'd0);
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
      end
    end

    // Backpressure: issue every cycle with writeback stalled
    wb_ready_i = 1'b0;
    nt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_tag_i   = 6'(nt);
      issue_dest_i  = 5'(nt + 1);
      issue_res     = 32'hA000_0000 + 32'(nt);
      @(negedge clk_i);
      if (issue_ready_o) nt++;
    end
    check("bp_accepted", 64'(nt), 64'd4);
    check("bp_occupancy", 64'(occupancy_o), 64'd4);
    check("bp_issue_ready", 64'(issue_ready_o), 64'd0);

    // Drain: no same-cycle credit on the first pop
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    wb_ready_i    = 1'b1;
    @(negedge clk_i);
    check("drain_pop_cycle_ready", 64'(issue_ready_o), 64'd0);
    @(negedge clk_i);
    check("drain_next_ready", 64'(issue_ready_o), 64'd1);
    check("drain_occ3", 64'(occupancy_o), 64'd3);
    repeat (4) @(negedge clk_i);
    check("drain_empty", 64'(occupancy_o), 64'd0);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // Streaming: 8 back-to-back ops, pointers wrap
    base = delivered;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_tag_i   = 6'(16 + k);
      issue_dest_i  = 5'(k);
      issue_res     = $urandom;
      @(negedge clk_i);
      check($sformatf("stream%0d_ready", k), 64'(issue_ready_o), 64'd1);
    end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("stream_delivered", 64'(delivered - base), 64'd8);
    check("stream_perr", 64'(protocol_error_o), 64'd0);
    check("stream_occ", 64'(occupancy_o), 64'd0);

    // Flush with 3 buffered + 1 in flight, result arriving in the flush cycle
    wb_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_tag_i   = 6'(32 + k);
      issue_dest_i  = 5'(k + 8);
      issue_res     = 32'hF000_0000 + 32'(k);
    end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    flush_i       = 1'b1;
    @(negedge clk_i);
    check("flush_pre_occ", 64'(occupancy_o), 64'd3);
    check("flush_issue_ready", 64'(issue_ready_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    exp_q.delete();
    base = delivered;
    @(negedge clk_i);
    check("flush_occ", 64'(occupancy_o), 64'd0);
    check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    wb_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("flush_no_leak", 64'(delivered - base), 64'd0);
    check("flush_wb_valid_late", 64'(wb_valid_o), 64'd0);
    check("flush_perr", 64'(protocol_error_o), 64'd0);

    // Orphan result: sticky error, nothing buffered
    @(posedge clk_i); #1;
    orphan_req = 1'b1;
    @(posedge clk_i); #1;
    orphan_req = 1'b0;
    @(negedge clk_i);
    check("orphan_perr_before_edge", 64'(protocol_error_o), 64'd0);
    @(negedge clk_i);
    check("orphan_perr", 64'(protocol_error_o), 64'd1);
    check("orphan_occ", 64'(occupancy_o), 64'd0);
    check("orphan_wb_valid", 64'(wb_valid_o), 64'd0);
    repeat (3) @(negedge clk_i);
    check("orphan_perr_sticky", 64'(protocol_error_o), 64'd1);

    // Async reset mid-sequence with entries still buffered
    wb_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_tag_i   = 6'(48 + k);
      issue_dest_i  = 5'(k);
      issue_res     = 32'h5555_0000 + 32'(k);
    end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    @(negedge clk_i);
    check("prereset_occ", 64'(occupancy_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("areset_occ", 64'(occupancy_o), 64'd0);
    check("areset_wb_valid", 64'(wb_valid_o), 64'd0);
    check("areset_issue_ready", 64'(issue_ready_o), 64'd1);
    check("areset_perr", 64'(protocol_error_o), 64'd0);
    @(posedge clk_i); #1;
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("post_reset_occ", 64'(occupancy_o), 64'd0);
    check("post_reset_perr", 64'(protocol_error_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bmu_result_buffer.md
Name: bmu_result_buffer

Overview:
Downstream stage of the bit manipulation unit (BMU). It pairs each 1-cycle-latency BMU result with the instruction tag and destination register captured at issue. Results are queued in a small FIFO and drained to writeback over a valid/ready handshake. A credit check on issue_ready_o means a BMU result is never dropped, so the BMU pipeline never has to stall.

Parameters:
DATA_WIDTH, 32, result width; equals the BMU data word.
TAG_WIDTH, 6, reorder-buffer tag width.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
flush_i  in  1  pipeline flush; discards all buffered and in-flight results
issue_valid_i  in  1  instruction dispatched to the BMU this cycle
issue_ready_o  out  1  buffer can accept one more BMU issue
issue_tag_i  in  TAG_WIDTH  tag of the issued instruction
issue_dest_i  in  5  destination register of the issued instruction
bmu_result_i  in  DATA_WIDTH  BMU result
bmu_valid_i  in  1  BMU result valid
wb_valid_o  out  1  head entry valid toward writeback
wb_ready_i  in  1  writeback accepts the head entry
wb_result_o  out  DATA_WIDTH  head result
wb_tag_o  out  TAG_WIDTH  head tag
wb_dest_o  out  5  head destination register
occupancy_o  out  $clog2(DEPTH)+1  number of valid FIFO entries
protocol_error_o  out  1  sticky: BMU result arrived with no matching in-flight tag

Behaviour:
- Reset state: FIFO empty, in-flight stage empty, all pointers 0, protocol_error_o = 0.
- Outputs after reset: wb_valid_o = 0, occupancy_o = 0, issue_ready_o = 1. wb_result_o, wb_tag_o and wb_dest_o are don't-care while wb_valid_o = 0.
- Issue: an issue is accepted when issue_valid_i & issue_ready_o. On acceptance, tag and dest are registered into the in-flight stage (inflight_valid = 1) at the next edge.
- Alignment: the BMU result arrives one cycle after issue. So bmu_valid_i is high in the same cycle inflight_valid is high.
- FIFO write: push {bmu_result_i, inflight tag, inflight dest} when bmu_valid_i & inflight_valid & !flush_i.
- Protocol error: bmu_valid_i & !inflight_valid sets protocol_error_o. It is cleared only by reset, and the orphan result is dropped.
- Credit rule: issue_ready_o = (DEPTH − occupancy − inflight_valid) ≥ 1.
  - Computed from registered state only. A same-cycle pop does not create credit, so no combinational path exists from wb_ready_i to issue_ready_o.
  - issue_ready_o is 0 while flush_i is high.
- Writeback handshake:
  - wb_valid_o = occupancy ≠ 0. wb outputs come directly from the head entry register.
  - Pop on wb_valid_o & wb_ready_i.
  - Once asserted, wb_valid_o and the head data stay stable until popped or flushed.
- Simultaneous push and pop: occupancy is unchanged. This is legal when full, provided the credit rule already guaranteed a free slot for the in-flight result.
- Full: occupancy = DEPTH implies inflight_valid = 0 and issue_ready_o = 0. A push while full is unreachable; verification checks this with an assertion.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is a separate counter.
- Flush: has priority over push and pop. At the next edge, occupancy = 0, pointers = 0 and inflight_valid = 0. wb_valid_o is 0 from that edge onward. A concurrent issue is ignored.
- Reset mid-operation: clears everything asynchronously, including entries not yet popped.

Optional Feature:
BMU_RESULT_BYPASS_EN
- Defined: when the FIFO is empty and a valid push occurs, the wb_* outputs present the incoming result combinationally in the same cycle, with wb_valid_o = 1. If wb_ready_i = 1 in that cycle, the entry is consumed and not written, giving 0 added latency.
- Undefined: results are visible on wb_* no earlier than the cycle after the push, giving 1 cycle of added latency.

Decomposition:
- integer_unit_pkg: bmu_wb_packet_t struct {result, tag, dest}, plus a TAG_WIDTH-based rob_tag_t if one is not already present.
- Sub-module: result_fifo, a generic synchronous FIFO of bmu_wb_packet_t with push, pop, flush, occupancy and head outputs.
- Top level: in-flight stage, credit logic, error flag and the bypass mux.

Test Plan:
- Single op, wb_ready_i = 1: issue tag=5, dest=3 at t0; bmu_result_i=0xDEADBEEF at t1 → wb_valid_o at t2 with {0xDEADBEEF, 5, 3}. With BMU_RESULT_BYPASS_EN, this appears at t1.
- Backpressure, DEPTH=4, wb_ready_i = 0, issue every cycle: exactly 4 issues accepted (tags 0..3). Then issue_ready_o = 0, occupancy_o = 4.
- Drain: raise wb_ready_i in the previous state → pops tags 0,1,2,3 in order. issue_ready_o returns to 1 the cycle after the first pop.
- Continuous streaming with 8 ops and wb_ready_i = 1 → all 8 delivered in order, pointer wrap exercised, protocol_error_o stays 0.
- Flush: hold 3 entries plus 1 in flight, assert flush_i for one cycle together with bmu_valid_i → next cycle occupancy_o = 0 and wb_valid_o = 0, and the in-flight result never appears.
- Orphan result: bmu_valid_i = 1 with no prior issue → protocol_error_o = 1 and stays 1; occupancy_o is unchanged. Async reset mid-sequence → all outputs return to their reset values immediately.
